// File: rtl/clk_div_meter.sv
// clk_div_meter: measures the period and high time of a slow signal (typically
// a divider output) sampled in the clk_in domain, and recovers the divide
// setting as period/2.
//
// Optional feature macro: CLK_DIV_METER_AVG4_EN
//   When defined, period/high_time are averages over 4 consecutive periods and
//   valid pulses once per group of 4.
//
// Ports:
//   clk_in      measurement clock (rising edge)
//   rst_n       asynchronous active-low reset
//   sig_in      signal to measure, asynchronous to clk_in
//   start       1-cycle pulse, arms a measurement from IDLE
//   continuous  1 = re-arm automatically after each result
//   busy        high whenever the FSM is not IDLE
//   valid       1-cycle pulse, result outputs updated this cycle
//   period      clk_in cycles between consecutive sig_in rising edges
//   high_time   clk_in cycles sig_in was sampled high within that period
//   div_est     period>>1, saturating at 255
//   timeout     sticky, no edge seen for 2^CNT_W-1 cycles
module clk_div_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [7:0]       div_est,
    output logic             timeout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] MEAS = 2'd2;

    // Last count before the counter would reach 2^CNT_W-1.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]             state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0]       hcnt, hcnt_nxt;
    logic [CNT_W-1:0]       period_nxt, high_time_nxt;
    logic [7:0]             div_est_nxt;
    logic                   valid_nxt, timeout_nxt, busy_nxt;
    logic                   res_load;
    logic [CNT_W-1:0]       res_p, res_h;
    logic [31:0]            half;

`ifdef CLK_DIV_METER_AVG4_EN
    logic [CNT_W+1:0]       psum, psum_nxt, hsum, hsum_nxt;
    logic [CNT_W+1:0]       psum_add, hsum_add;
    logic [1:0]             grp, grp_nxt;
`endif

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hcnt_nxt      = hcnt;
        period_nxt    = period;
        high_time_nxt = high_time;
        div_est_nxt   = div_est;
        valid_nxt     = 1'b0;
        timeout_nxt   = timeout;
        res_load      = 1'b0;
        res_p         = cnt;
        res_h         = hcnt;
        half          = 32'd0;
`ifdef CLK_DIV_METER_AVG4_EN
        psum_nxt      = psum;
        hsum_nxt      = hsum;
        grp_nxt       = grp;
        psum_add      = psum + {2'b00, cnt};
        hsum_add      = hsum + {2'b00, hcnt};
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = ARM;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b0;
                end
            end
            ARM: begin
                if (rise) begin
                    state_nxt = MEAS;
                    cnt_nxt   = CNT_ONE;
                    hcnt_nxt  = CNT_ONE;
`ifdef CLK_DIV_METER_AVG4_EN
                    psum_nxt  = '0;
                    hsum_nxt  = '0;
                    grp_nxt   = 2'd0;
`endif
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state_nxt   = IDLE;
                        timeout_nxt = 1'b1;
                    end
                end
            end
            MEAS: begin
                if (rise) begin
                    cnt_nxt  = CNT_ONE;
                    hcnt_nxt = CNT_ONE;
`ifdef CLK_DIV_METER_AVG4_EN
                    // Accumulate; report and re-evaluate continuous only at group end.
                    if (grp == 2'd3) begin
                        res_load = 1'b1;
                        res_p    = psum_add[CNT_W+1:2];
                        res_h    = hsum_add[CNT_W+1:2];
                        psum_nxt = '0;
                        hsum_nxt = '0;
                        grp_nxt  = 2'd0;
                        if (!continuous) state_nxt = IDLE;
                    end else begin
                        psum_nxt = psum_add;
                        hsum_nxt = hsum_add;
                        grp_nxt  = grp + 2'd1;
                    end
`else
                    res_load = 1'b1;
                    if (!continuous) state_nxt = IDLE;
`endif
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt  = cnt + CNT_ONE;
                    hcnt_nxt = hcnt + CNT_W'(s);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (res_load) begin
            period_nxt    = res_p;
            high_time_nxt = res_h;
            half          = 32'(res_p) >> 1;
            div_est_nxt   = (half > 32'd255) ? 8'hFF : half[7:0];
            valid_nxt     = 1'b1;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sync_q    <= '0;
            s_d       <= 1'b0;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            div_est   <= 8'd0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
`ifdef CLK_DIV_METER_AVG4_EN
            psum      <= '0;
            hsum      <= '0;
            grp       <= 2'd0;
`endif
        end else begin
            state     <= state_nxt;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d       <= s;
            cnt       <= cnt_nxt;
            hcnt      <= hcnt_nxt;
            period    <= period_nxt;
            high_time <= high_time_nxt;
            div_est   <= div_est_nxt;
            valid     <= valid_nxt;
            timeout   <= timeout_nxt;
            busy      <= busy_nxt;
`ifdef CLK_DIV_METER_AVG4_EN
            psum      <= psum_nxt;
            hsum      <= hsum_nxt;
            grp       <= grp_nxt;
`endif
        end
    end

endmodule
